// File: rtl/systolic_west_feeder.sv
// West-edge feeder: FIFO-buffered tiles are released as gap-free bursts with diagonal row skew.
// Optional build macro FEEDER_ZERO_GATE_EN forces lane data to zero whenever that lane is not valid.
module systolic_west_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   in_data,
  input  logic                     in_switch,
  input  logic                     in_last,
  output logic [ROWS*DATA_W-1:0]   row_input,
  output logic [ROWS-1:0]          row_valid,
  output logic [ROWS-1:0]          row_switch,
  output logic                     busy,
  output logic                     tile_done,
  output logic                     err_underrun
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW  = ROWS*DATA_W + 2;
  localparam int DCW = $clog2(ROWS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [EW-1:0]           mem [DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr, count;
  logic [AW:0]             last_cnt, last_cnt_next;
  logic [DCW-1:0]          drain_cnt, drain_cnt_next;
  logic                    full, empty, push, pop;
  logic [EW-1:0]           head;
  logic [ROWS*DATA_W-1:0]  head_data;
  logic                    head_switch, head_last;
  logic [ROWS-1:0]         valid_pipe, switch_pipe, last_pipe;

  // FIFO bookkeeping
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign pop       = (state == STREAM) & ~empty;

  assign head        = mem[rd_ptr[AW-1:0]];
  assign head_data   = head[EW-1:2];
  assign head_switch = head[1];
  assign head_last   = head[0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_data, in_switch, in_last};
  end

  always_comb begin
    last_cnt_next = last_cnt;
    case ({push & in_last, pop & head_last})
      2'b10:   last_cnt_next = last_cnt + 1'b1;
      2'b01:   last_cnt_next = last_cnt - 1'b1;
      default: last_cnt_next = last_cnt;
    endcase
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      IDLE: begin
        if (last_cnt != '0 || full) state_next = STREAM;
      end
      STREAM: begin
        // Leave only once the final queued tile has popped its last beat.
        if (pop && head_last && last_cnt_next == '0) begin
          if (ROWS > 1) begin
            state_next     = DRAIN;
            drain_cnt_next = DCW'(ROWS-1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt <= DCW'(1)) state_next = IDLE;
        else                      drain_cnt_next = drain_cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_cnt     <= '0;
      err_underrun <= 1'b0;
      valid_pipe   <= '0;
      switch_pipe  <= '0;
      last_pipe    <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      last_cnt  <= last_cnt_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (state == STREAM && empty) err_underrun <= 1'b1;
      // Bit r of each pipe is the pop-point flag delayed r cycles, i.e. lane r.
      valid_pipe  <= (valid_pipe  << 1) | ROWS'(pop);
      switch_pipe <= (switch_pipe << 1) | ROWS'(pop & head_switch);
      last_pipe   <= (last_pipe   << 1) | ROWS'(pop & head_last);
    end
  end

  assign row_valid  = valid_pipe;
  assign row_switch = switch_pipe;
  assign tile_done  = last_pipe[ROWS-1];
  assign busy       = (state != IDLE);

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    localparam int CHW = (r+1)*DATA_W;
    logic [CHW-1:0]    chain;
    logic [DATA_W-1:0] stage0_next;

`ifdef FEEDER_ZERO_GATE_EN
    assign stage0_next = pop ? head_data[r*DATA_W +: DATA_W] : '0;
`else
    assign stage0_next = pop ? head_data[r*DATA_W +: DATA_W] : chain[DATA_W-1:0];
`endif

    // Stage 0 is the pop point; the oldest stage (top slice) drives the lane.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) chain <= '0;
      else      chain <= (chain << DATA_W) | CHW'(stage0_next);
    end

    assign row_input[r*DATA_W +: DATA_W] = chain[CHW-1 -: DATA_W];
  end

endmodule

// File: tb/tb_systolic_west_feeder.sv
// Directed bench for systolic_west_feeder: vector table for single/back-to-back tiles and switch
// alignment, plus hand sequences for forced start/underrun and mid-burst reset.
module tb_systolic_west_feeder;
  localparam int ROWS   = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
`ifdef FEEDER_ZERO_GATE_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] in_data = '0;
  logic                   in_switch = 1'b0;
  logic                   in_last = 1'b0;
  logic [ROWS*DATA_W-1:0] row_input;
  logic [ROWS-1:0]        row_valid, row_switch;
  logic                   busy, tile_done, err_underrun;

  int checks = 0;
  int errors = 0;

  systolic_west_feeder #(.ROWS(ROWS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_switch(in_switch), .in_last(in_last), .row_input(row_input), .row_valid(row_valid),
    .row_switch(row_switch), .busy(busy), .tile_done(tile_done), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        sw;
    logic        last;
    logic [3:0]  ev;
    logic [3:0]  es;
    logic        etd;
    logic        ebusy;
    logic [3:0]  dm;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [31:0] beat(input int k);
    return {8'(10*k+3), 8'(10*k+2), 8'(10*k+1), 8'(10*k)};
  endfunction

  function automatic int z(input int x);
    return ZG ? 0 : x;
  endfunction

  function automatic logic [31:0] ln(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic sw, input logic last,
                              input logic [3:0] ev, input logic [3:0] es, input logic etd,
                              input logic ebusy, input logic [3:0] dm, input logic [31:0] ed);
    vec_t v;
    v.iv = iv; v.d = d; v.sw = sw; v.last = last; v.ev = ev; v.es = es;
    v.etd = etd; v.ebusy = ebusy; v.dm = dm; v.ed = ed;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  initial begin
    // single tile (last accepted at vector 2 = edge N)
    vecs[0]  = mk(1, beat(1), 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111, ln(0, 0, 0, 0));
    vecs[1]  = mk(1, beat(2), 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111, ln(0, 0, 0, 0));
    vecs[2]  = mk(1, beat(3), 0, 1, 4'b0000, 4'b0000, 0, 0, 4'b1111, ln(0, 0, 0, 0));
    vecs[3]  = mk(0, '0,      0, 0, 4'b0000, 4'b0000, 0, 1, 4'b1111, ln(0, 0, 0, 0));
    vecs[4]  = mk(0, '0,      0, 0, 4'b0001, 4'b0000, 0, 1, 4'b0001, ln(10, 0, 0, 0));
    vecs[5]  = mk(0, '0,      0, 0, 4'b0011, 4'b0000, 0, 1, 4'b0011, ln(20, 11, 0, 0));
    vecs[6]  = mk(0, '0,      0, 0, 4'b0111, 4'b0000, 0, 1, 4'b0111, ln(30, 21, 12, 0));
    vecs[7]  = mk(0, '0,      0, 0, 4'b1110, 4'b0000, 0, 1, 4'b1111, ln(z(30), 31, 22, 13));
    vecs[8]  = mk(0, '0,      0, 0, 4'b1100, 4'b0000, 0, 1, 4'b1111, ln(z(30), z(31), 32, 23));
    vecs[9]  = mk(0, '0,      0, 0, 4'b1000, 4'b0000, 1, 0, 4'b1111, ln(z(30), z(31), z(32), 33));
    vecs[10] = mk(0, '0,      0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111, ln(z(30), z(31), z(32), z(33)));
    // back-to-back tiles A{1,2} and B{3,4}, switch on beat 1
    vecs[11] = mk(1, beat(1), 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, ln(0, 0, 0, 0));
    vecs[12] = mk(1, beat(2), 0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000, ln(0, 0, 0, 0));
    vecs[13] = mk(1, beat(3), 0, 0, 4'b0000, 4'b0000, 0, 1, 4'b0000, ln(0, 0, 0, 0));
    vecs[14] = mk(1, beat(4), 0, 1, 4'b0001, 4'b0001, 0, 1, 4'b0001, ln(10, 0, 0, 0));
    vecs[15] = mk(0, '0,      0, 0, 4'b0011, 4'b0010, 0, 1, 4'b0011, ln(20, 11, 0, 0));
    vecs[16] = mk(0, '0,      0, 0, 4'b0111, 4'b0100, 0, 1, 4'b0111, ln(30, 21, 12, 0));
    vecs[17] = mk(0, '0,      0, 0, 4'b1111, 4'b1000, 0, 1, 4'b1111, ln(40, 31, 22, 13));
    vecs[18] = mk(0, '0,      0, 0, 4'b1110, 4'b0000, 1, 1, 4'b1110, ln(0, 41, 32, 23));
    vecs[19] = mk(0, '0,      0, 0, 4'b1100, 4'b0000, 0, 1, 4'b1100, ln(0, 0, 42, 33));
    vecs[20] = mk(0, '0,      0, 0, 4'b1000, 4'b0000, 1, 0, 4'b1000, ln(0, 0, 0, 43));
    vecs[21] = mk(0, '0,      0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111, ln(z(40), z(41), z(42), z(43)));

    // reset state
    tick();
    tick();
    chk("rst row_valid", 32'(row_valid), 32'(0));
    chk("rst row_switch", 32'(row_switch), 32'(0));
    chk("rst row_input", row_input, 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst tile_done", 32'(tile_done), 32'(0));
    chk("rst err", 32'(err_underrun), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post-rst in_ready", 32'(in_ready), 32'(1));

    for (int i = 0; i < 22; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      in_switch = vecs[i].sw;
      in_last   = vecs[i].last;
      tick();
      chk($sformatf("v%0d row_valid", i), 32'(row_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d row_switch", i), 32'(row_switch), 32'(vecs[i].es));
      chk($sformatf("v%0d tile_done", i), 32'(tile_done), 32'(vecs[i].etd));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].ebusy));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(1));
      chk($sformatf("v%0d err", i), 32'(err_underrun), 32'(0));
      for (int r = 0; r < ROWS; r++)
        if (vecs[i].dm[r])
          chk($sformatf("v%0d lane%0d", i, r), 32'(row_input[r*DATA_W +: DATA_W]),
              32'(vecs[i].ed[r*DATA_W +: DATA_W]));
    end

    // forced start on full FIFO, held-off 9th beat, then underrun bubble
    in_switch = 1'b0;
    in_last   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = beat(k);
      tick();
      chk($sformatf("fill%0d in_ready", k), 32'(in_ready), 32'(k < 8));
      chk($sformatf("fill%0d busy", k), 32'(busy), 32'(0));
    end
    in_data = beat(9);
    tick();
    chk("full in_ready", 32'(in_ready), 32'(0));
    chk("forced busy", 32'(busy), 32'(1));
    chk("forced rv0", 32'(row_valid[0]), 32'(0));
    tick();
    chk("pop1 in_ready", 32'(in_ready), 32'(1));
    chk("pop1 rv0", 32'(row_valid[0]), 32'(1));
    chk("pop1 lane0", 32'(row_input[7:0]), 32'(10));
    tick();
    in_valid = 1'b0;
    chk("pop2 lane0", 32'(row_input[7:0]), 32'(20));
    for (int k = 3; k <= 9; k++) begin
      tick();
      chk($sformatf("pop%0d rv0", k), 32'(row_valid[0]), 32'(1));
      chk($sformatf("pop%0d lane0", k), 32'(row_input[7:0]), 32'(10*k));
      chk($sformatf("pop%0d err", k), 32'(err_underrun), 32'(0));
    end
    tick();
    chk("bubble rv0", 32'(row_valid[0]), 32'(0));
    chk("bubble err", 32'(err_underrun), 32'(1));
    chk("bubble busy", 32'(busy), 32'(1));
    chk("bubble lane0", 32'(row_input[7:0]), 32'(z(90)));
    tick();
    tick();
    chk("sticky err", 32'(err_underrun), 32'(1));
    chk("sticky rv0", 32'(row_valid[0]), 32'(0));

    // mid-burst reset
    in_valid = 1'b1;
    in_data  = beat(1);
    tick();
    in_data = beat(2);
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("burst rv0", 32'(row_valid[0]), 32'(1));
    chk("burst lane0", 32'(row_input[7:0]), 32'(10));
    #2 rst = 1'b0;
    #1;
    chk("midrst row_valid", 32'(row_valid), 32'(0));
    chk("midrst row_switch", 32'(row_switch), 32'(0));
    chk("midrst row_input", row_input, 32'(0));
    chk("midrst busy", 32'(busy), 32'(0));
    chk("midrst err", 32'(err_underrun), 32'(0));
    chk("midrst tile_done", 32'(tile_done), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("after%0d in_ready", c), 32'(in_ready), 32'(1));
      chk($sformatf("after%0d busy", c), 32'(busy), 32'(0));
      chk($sformatf("after%0d row_valid", c), 32'(row_valid), 32'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
